// File: rtl/initiator_ctrl_if.sv
// initiator_ctrl_if: command/response handshake plus target select/data bus.
// The master modport is the initiator's view; the slave modport is the command source and target side.
interface initiator_ctrl_if #(parameter int BURST_LEN = 8);
   logic                   cmd_valid;
   logic                   cmd_ready;
   logic                   cmd_write;
   logic [8*BURST_LEN-1:0] cmd_wdata;
   logic                   rsp_valid;
   logic                   rsp_err;
   logic [8*BURST_LEN-1:0] rsp_rdata;
   logic                   dup_warn;
   logic                   sel_bit;
   logic                   trdy;
   logic [8:0]             datain;
   logic [7:0]             dataout;
   modport master (
      input  cmd_valid, cmd_write, cmd_wdata, trdy, dataout,
      output cmd_ready, rsp_valid, rsp_err, rsp_rdata, dup_warn, sel_bit, datain
   );
   modport slave (
      output cmd_valid, cmd_write, cmd_wdata, trdy, dataout,
      input  cmd_ready, rsp_valid, rsp_err, rsp_rdata, dup_warn, sel_bit, datain
   );
endinterface

// File: rtl/initiator_ctrl.sv
// initiator_ctrl: turns one write/read burst command into the target's sel_bit/trdy/datain sequence.
// Every output comes from a register; trdy is active-low.
module initiator_ctrl #(
   parameter int BURST_LEN    = 8,
   parameter int TRDY_TIMEOUT = 16
) (
   input logic               clk,
   input logic               reset,
   initiator_ctrl_if.master  bus
);
   localparam int IW = $clog2(BURST_LEN);
   localparam int BW = IW + 1;
   localparam int DW = 8 * BURST_LEN;
   typedef enum logic [2:0] {IDLE, SELECT, WRITE, RD_REQ, RD_CAP, RELEASE, DONE} state_t;
   state_t          state, state_n;
   logic            wr_q, wr_n;
   logic [DW-1:0]   wdata_q, wdata_n, rbuf_q, rbuf_n, rdata_q, rdata_n;
   logic [BW-1:0]   beat_q, beat_n;
   logic [7:0]      tcnt_q, tcnt_n;
   logic            sel_q, sel_n, vld_q, vld_n, err_q, err_n, dup_q, dup_n;
   logic [8:0]      din_q, din_n;
   logic [7:0]      wbyte;
   logic            dup;
   assign wbyte = wdata_q[{beat_q[IW-1:0], 3'b000} +: 8];
   // Target stores only when datain changes, so equal neighbours collapse into one byte.
   always_comb begin
      dup = 1'b0;
      for (int i = 1; i < BURST_LEN; i++)
         dup = dup | (bus.cmd_wdata[8*i +: 8] == bus.cmd_wdata[8*(i-1) +: 8]);
   end
   always_comb begin
      state_n = state;
      wr_n    = wr_q;
      wdata_n = wdata_q;
      rbuf_n  = rbuf_q;
      rdata_n = rdata_q;
      beat_n  = beat_q;
      tcnt_n  = tcnt_q;
      sel_n   = sel_q;
      din_n   = din_q;
      err_n   = err_q;
      vld_n   = 1'b0;
      dup_n   = 1'b0;
      unique case (state)
         IDLE: if (bus.cmd_valid) begin
            state_n = SELECT;
            wr_n    = bus.cmd_write;
            wdata_n = bus.cmd_wdata;
            sel_n   = 1'b1;
            din_n   = 9'h000;
            err_n   = 1'b0;
            tcnt_n  = 8'd0;
            beat_n  = '0;
            dup_n   = bus.cmd_write && dup;
         end
         SELECT: if (!bus.trdy) begin
            state_n = wr_q ? WRITE : RD_REQ;
            din_n   = wr_q ? {1'b1, wbyte} : 9'h000;
            beat_n  = wr_q ? BW'(1) : '0;
         end else begin
            tcnt_n = tcnt_q + 8'd1;
            if (tcnt_q == 8'(TRDY_TIMEOUT - 1)) begin
               state_n = RELEASE;
               sel_n   = 1'b0;
               err_n   = 1'b1;
            end
         end
         // The last byte stays on datain through RELEASE while trdy may still be low.
         WRITE: begin
            err_n = err_q | bus.trdy;
            if (beat_q == BW'(BURST_LEN)) begin
               state_n = RELEASE;
               sel_n   = 1'b0;
            end else begin
               din_n  = {1'b1, wbyte};
               beat_n = beat_q + 1'b1;
            end
         end
         RD_REQ: begin
            state_n = RD_CAP;
            beat_n  = '0;
         end
         RD_CAP: begin
            err_n = err_q | bus.trdy;
            rbuf_n[{beat_q[IW-1:0], 3'b000} +: 8] = bus.dataout;
            beat_n = beat_q + 1'b1;
            if (beat_q == BW'(BURST_LEN - 1)) begin
               state_n = RELEASE;
               sel_n   = 1'b0;
               rdata_n = rbuf_n;
            end
         end
         RELEASE: if (bus.trdy) begin
            state_n = DONE;
            vld_n   = 1'b1;
            din_n   = 9'h000;
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         rbuf_q  <= '0;
         rdata_q <= '0;
         beat_q  <= '0;
         tcnt_q  <= 8'd0;
         sel_q   <= 1'b0;
         din_q   <= 9'h000;
         vld_q   <= 1'b0;
         err_q   <= 1'b0;
         dup_q   <= 1'b0;
      end else begin
         state   <= state_n;
         wr_q    <= wr_n;
         wdata_q <= wdata_n;
         rbuf_q  <= rbuf_n;
         rdata_q <= rdata_n;
         beat_q  <= beat_n;
         tcnt_q  <= tcnt_n;
         sel_q   <= sel_n;
         din_q   <= din_n;
         vld_q   <= vld_n;
         err_q   <= err_n;
         dup_q   <= dup_n;
      end
   end
   assign bus.cmd_ready = (state == IDLE);
   assign bus.rsp_valid = vld_q;
   assign bus.rsp_err   = err_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.dup_warn  = dup_q;
   assign bus.sel_bit   = sel_q;
   assign bus.datain    = din_q;
endmodule

// File: doc/initiator_ctrl.md
Name: initiator_ctrl

Overview:
Bus initiator stage that drives the target's select/data interface: it turns one command (an 8-byte write burst or an 8-byte read burst) into the sel_bit/trdy/datain sequence the target expects. For reads, it collects the 8 bytes the target returns on dataout. It returns a single response per command to the upstream command source, with timeout detection on trdy. Synthesizable RTL that also serves as the master BFM in the prototype bench.

Parameters:
BURST_LEN, 8, beats per burst; must match the target's fixed burst of 8.
TRDY_TIMEOUT, 16, max cycles in SELECT waiting for trdy low before error; range 1..255.

Ports:
clk  in  1  clock; all logic on posedge.
reset  in  1  asynchronous, active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  high only in IDLE; a command is accepted on any edge where cmd_valid && cmd_ready.
cmd_write  in  1  1 = write burst, 0 = read burst.
cmd_wdata  in  8*BURST_LEN  write bytes; beat i = cmd_wdata[8i+7:8i].
rsp_valid  out  1  one-cycle pulse when the command completes.
rsp_err  out  1  valid with rsp_valid; 1 = trdy timeout.
rsp_rdata  out  8*BURST_LEN  read bytes; beat i in [8i+7:8i]; holds until the next read completes.
dup_warn  out  1  one-cycle pulse at acceptance of a write whose consecutive bytes are equal (the target stores only on datain change).
sel_bit  out  1  select to target.
trdy  in  1  target ready, active-low.
datain  out  9  to target: bit8 = write flag, [7:0] = byte.
dataout  in  8  read data from target.

Behaviour:
- Reset (async, active-low): state=IDLE; sel_bit=0, datain=9'h000, rsp_valid=0, rsp_err=0, rsp_rdata=0, dup_warn=0, beat counter=0, timeout counter=0. Reset asserted mid-burst aborts immediately with no response.
- All outputs are registered.
- Accept: latch cmd_write and cmd_wdata. Next state is SELECT. sel_bit goes high the cycle after acceptance.
- SELECT: hold sel_bit=1 and datain=9'h000. On the first edge with trdy==0 sampled:
  - write: go to WRITE.
  - read: go to RD_REQ.
  - Timeout counter increments each cycle in SELECT. When it reaches TRDY_TIMEOUT with trdy still 1: set rsp_err=1 and go to RELEASE.
- WRITE: for beat i = 0..BURST_LEN-1, drive datain={1'b1, byte i} for exactly one cycle each, starting the cycle after trdy was sampled low. After the last beat, go to RELEASE and keep datain at the last value (it must not change while trdy may still be low).
- RD_REQ: drive datain=9'h000 for one cycle (target samples bit8=0 with sel high and trdy low), then go to RD_CAP.
- RD_CAP: capture dataout into byte i on each of the next BURST_LEN edges. The first capture is on the edge after RD_REQ's sampling edge. After the BURST_LEN-th capture, go to RELEASE in the same edge so sel_bit falls before the target can re-trigger a read. datain stays 9'h000.
- RELEASE: sel_bit=0. Wait for trdy==1 sampled, then go to DONE. No timeout in RELEASE.
- DONE: rsp_valid=1 for one cycle. datain returns to 9'h000 (safe, since sel is low and trdy is high). Then back to IDLE; rsp_err clears on the next acceptance.
- cmd_valid outside IDLE is ignored (cmd_ready=0). Back-to-back commands: the next command can be accepted no earlier than the cycle after DONE.
- trdy rising while in WRITE or RD_CAP is a protocol error: finish the burst anyway and set rsp_err=1.
- Beat counter is log2(BURST_LEN)+1 bits and saturates; it never wraps within a burst.

Test Plan:
1. Write cmd_wdata=64'h0807060504030201, target compliant:
   - sel_bit rises 1 cycle after accept.
   - datain steps 9'h101..9'h108 on consecutive cycles starting the cycle after trdy is sampled low.
   - rsp_valid=1, rsp_err=0; target wi advances by 8.
2. Read after scenario 1 with target ri=0:
   - one datain=9'h000 request cycle, then 8 captures.
   - rsp_rdata=64'h0807060504030201; sel_bit low before target re-samples.
3. Target holds trdy=1 for 20 cycles, TRDY_TIMEOUT=16:
   - sel_bit drops after 16 SELECT cycles; rsp_valid with rsp_err=1; no datain bit8 activity.
4. Write cmd_wdata=64'h1111111111111111:
   - dup_warn pulse at accept; burst still completes with rsp_err=0.
5. reset driven low during beat 4 of a write:
   - immediately sel_bit=0, datain=9'h000, cmd_ready=1 after release, no rsp_valid.
6. cmd_valid held high for two commands (write then read):
   - second accepted only after the first rsp_valid; cmd_ready=0 throughout the first burst.
